multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Main FSM of the multi-cycle RV32I core. It sequences every instruction through fetch, decode, execute, memory and write-back, and drives all datapath strobes and mux selects.
- It sits directly upstream of alu_control_unit. Its alu_op_mode output selects whether the ALU does a forced ADD, a branch compare, or the funct3/funct7-decoded operation.

Parameters:
- MEM_LATENCY, 1: cycles that each memory access (instruction fetch or data access) occupies. Legal range is 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  7  IR[6:0]; valid from ID onward.
- bcond  input  1  branch-taken flag from the ALU; sampled in EX of BRANCH.
- ecall_halt  input  1  high when x17==10; sampled in ID of ECALL.
- pc_write  output  1  PC register write enable.
- pc_source  output  1  PC input select: 0 = ALU result, 1 = ALUOut.
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  IR load enable.
- mem_to_reg  output  1  rd data select: 0 = ALUOut, 1 = MDR.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = rs1.
- alu_src_b  output  2  ALU B select: 00 = rs2, 01 = constant 4, 10 = imm.
- alu_op_mode  output  2  mode for alu_control_unit: 00 = ADD, 01 = BRANCH, 10 = FUNCT.
- is_halted  output  1  sticky halt indication.

Behaviour:
- Reset:
  - While reset is low, state = IF, wait counter = 0, and all outputs are forced to 0, combinationally and asynchronously.
  - is_halted clears on reset.
- State register: 3 bits. States are IF, ID, EX, MEM, WB, PC4, HALT.
- Output defaults: every output is 0 in every state unless listed below.
- IF:
  - mem_read = 1, i_or_d = 0.
  - Stays MEM_LATENCY cycles. ir_write = 1 only on the last cycle, then go to ID.
- ID:
  - a = PC, b = imm, ADD; this latches the branch/JAL target into ALUOut.
  - Next state by opcode:
    - ARITHMETIC, ARITHMETIC_IMM, LOAD, STORE, BRANCH, JAL, JALR: go to EX.
    - ECALL: go to HALT if ecall_halt, otherwise PC4.
    - Any other opcode: go to PC4 (executes as a NOP).
- EX:
  - ARITHMETIC: a = rs1, b = rs2, FUNCT; go to WB.
  - ARITHMETIC_IMM: a = rs1, b = imm, FUNCT; go to WB.
  - LOAD/STORE: a = rs1, b = imm, ADD; go to MEM.
  - BRANCH: a = rs1, b = rs2, BRANCH.
    - bcond = 1: pc_write = 1, pc_source = 1; go to IF. Branch total is 3 cycles at MEM_LATENCY = 1.
    - bcond = 0: go to PC4.
  - JAL: pc_write = 1, pc_source = 1. Same cycle, a = PC, b = 4, ADD, so ALUOut = old PC + 4. Go to WB.
  - JALR: a = PC, b = 4, ADD; go to WB.
- MEM:
  - i_or_d = 1. LOAD drives mem_read = 1; STORE drives mem_write = 1.
  - Stays MEM_LATENCY cycles, then LOAD goes to WB and STORE goes to PC4.
- WB:
  - ARITHMETIC/ARITHMETIC_IMM/LOAD:
    - reg_write = 1; mem_to_reg = 1 for LOAD, 0 otherwise.
    - Also a = PC, b = 4, ADD, pc_write = 1, pc_source = 0.
  - JAL: reg_write = 1, mem_to_reg = 0, no PC write.
  - JALR: reg_write = 1, mem_to_reg = 0. Also a = rs1, b = imm, ADD, pc_write = 1, pc_source = 0.
  - All WB variants then go to IF.
- PC4: a = PC, b = 4, ADD, pc_write = 1, pc_source = 0; go to IF.
- HALT:
  - is_halted = 1 and all strobes are 0.
  - Absorbing: only reset leaves HALT. Opcode and bcond are ignored.
- Wait counter:
  - Width 4. Cleared on entry to IF and to MEM, increments each cycle in those states.
  - The last cycle is count == MEM_LATENCY-1. With MEM_LATENCY = 1 the first cycle is the last cycle.
- Mid-operation reset: any state, including a MEM store in progress, drops every strobe immediately. Execution restarts in IF.

Optional Feature:
- Macro: PERF_COUNTER_EN.
- Defined:
  - Adds outputs cycle_count[31:0] and retired_count[31:0], both reset to 0.
  - cycle_count increments every cycle while not halted.
  - retired_count increments on every transition into IF and on entry to HALT.
  - Both wrap modulo 2^32.
- Undefined: the ports and logic are absent.

Decomposition:
- Shared header (alongside opcodes.v): state encodings, the ALU_MODE_ADD/BRANCH/FUNCT constants, and the alu_src_b and pc_source select constants.
- Opcode values come from opcodes.v.
- One sub-module: mem_wait_counter (clear, enable, last-cycle flag, parameter MEM_LATENCY).

Test Plan:
- MEM_LATENCY = 1, opcode 0110011: states are IF, ID, EX, WB. The WB cycle shows reg_write = 1, pc_write = 1, pc_source = 0, alu_src_b = 01, alu_op_mode = 00. Back in IF at cycle 5.
- BRANCH with bcond = 1: the EX cycle has pc_write = 1, pc_source = 1, alu_op_mode = 01, for 3 cycles total. With bcond = 0: the sequence is IF, ID, EX, PC4, for 4 cycles total.
- MEM_LATENCY = 3, LOAD:
  - IF lasts 3 cycles with ir_write only in the 3rd.
  - MEM lasts 3 cycles with mem_read = 1, i_or_d = 1.
  - WB has mem_to_reg = 1. Total is 9 cycles.
- JAL: the EX cycle shows pc_write = 1, pc_source = 1 and WB has reg_write = 1 without pc_write. JALR: the WB cycle shows reg_write = 1, pc_write = 1, alu_src_a = 1, alu_src_b = 10.
- ECALL with ecall_halt = 1: goes to HALT with is_halted = 1, held for 20 cycles under changing opcode. ECALL with ecall_halt = 0: the sequence is IF, ID, PC4.
- Drive reset low in the 2nd MEM cycle of a STORE (MEM_LATENCY = 3): mem_write falls to 0 within the same cycle. After release, the unit is in IF with the counter at 0, and ir_write comes on the 3rd cycle.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit_pkg
//   Shared definitions for the multi-cycle RV32I control FSM:
//   - FSM state encodings (3-bit)
//   - alu_op_mode values consumed by alu_control_unit
//   - alu_src_a / alu_src_b / pc_source select values
//   - RV32I major opcodes (same values as opcodes.v)
//   - width of the memory wait counter
// -----------------------------------------------------------------------------
package multicycle_control_unit_pkg;

   typedef enum logic [2:0] {
      ST_IF   = 3'd0,
      ST_ID   = 3'd1,
      ST_EX   = 3'd2,
      ST_MEM  = 3'd3,
      ST_WB   = 3'd4,
      ST_PC4  = 3'd5,
      ST_HALT = 3'd6
   } state_t;

   // alu_op_mode encodings
   localparam logic [1:0] ALU_MODE_ADD    = 2'b00;
   localparam logic [1:0] ALU_MODE_BRANCH = 2'b01;
   localparam logic [1:0] ALU_MODE_FUNCT  = 2'b10;

   // ALU operand selects
   localparam logic       ALU_SRC_A_PC   = 1'b0;
   localparam logic       ALU_SRC_A_RS1  = 1'b1;
   localparam logic [1:0] ALU_SRC_B_RS2  = 2'b00;
   localparam logic [1:0] ALU_SRC_B_FOUR = 2'b01;
   localparam logic [1:0] ALU_SRC_B_IMM  = 2'b10;

   // PC input select
   localparam logic PC_SRC_ALU    = 1'b0;
   localparam logic PC_SRC_ALUOUT = 1'b1;

   // RV32I major opcodes (IR[6:0])
   localparam logic [6:0] OP_ARITHMETIC     = 7'b0110011;
   localparam logic [6:0] OP_ARITHMETIC_IMM = 7'b0010011;
   localparam logic [6:0] OP_LOAD           = 7'b0000011;
   localparam logic [6:0] OP_STORE          = 7'b0100011;
   localparam logic [6:0] OP_BRANCH         = 7'b1100011;
   localparam logic [6:0] OP_JAL            = 7'b1101111;
   localparam logic [6:0] OP_JALR           = 7'b1100111;
   localparam logic [6:0] OP_ECALL          = 7'b1110011;

   // Memory wait counter width (supports MEM_LATENCY up to 15)
   localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/multicycle_control_unit_mem_wait_counter.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit_mem_wait_counter
//   Counts the cycles spent in a memory-occupying state (IF or MEM) and flags
//   the last one (count == MEM_LATENCY-1).
//   Ports:
//     i_clk    - system clock, rising edge
//     i_rst_n  - asynchronous active-low reset
//     i_clear  - synchronous clear (takes priority over i_enable)
//     i_enable - increment this cycle
//     o_last   - current cycle is the last cycle of the access
// -----------------------------------------------------------------------------
module multicycle_control_unit_mem_wait_counter
   import multicycle_control_unit_pkg::*;
#(
   parameter int MEM_LATENCY = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_last
);

   localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(MEM_LATENCY - 1);

   logic [WAIT_CNT_W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + WAIT_CNT_W'(1);
      end
   end

   assign o_last = (r_count == LAST_CNT);

endmodule

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//   Main FSM of the multi-cycle RV32I core: IF -> ID -> EX -> MEM -> WB, plus
//   PC4 (plain PC+4 update) and an absorbing HALT state. Drives every datapath
//   strobe and mux select, and alu_op_mode for alu_control_unit.
//   Parameter:
//     MEM_LATENCY - cycles per memory access (1..15)
//   Ports:
//     clk, reset (async, active-low)
//     opcode[6:0], bcond, ecall_halt          - decode/status inputs
//     pc_write, pc_source, i_or_d, mem_read,
//     mem_write, ir_write, mem_to_reg,
//     reg_write, alu_src_a, alu_src_b[1:0],
//     alu_op_mode[1:0]                        - datapath controls
//     is_halted                               - sticky halt flag
//   Optional feature (macro PERF_COUNTER_EN):
//     cycle_count[31:0]   - cycles spent not halted
//     retired_count[31:0] - transitions into IF plus entry into HALT
// -----------------------------------------------------------------------------
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  opcode,
   input  logic        bcond,
   input  logic        ecall_halt,
   output logic        pc_write,
   output logic        pc_source,
   output logic        i_or_d,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op_mode,
   output logic        is_halted
`ifdef PERF_COUNTER_EN
   ,
   output logic [31:0] cycle_count,
   output logic [31:0] retired_count
`endif
);

   state_t r_state;
   state_t w_next;
   logic   w_last;
   logic   w_wait_clear;
   logic   w_wait_en;

   // Any state change restarts the count, so both IF and MEM begin at zero.
   assign w_wait_clear = (w_next != r_state);
   assign w_wait_en    = (r_state == ST_IF) || (r_state == ST_MEM);

   multicycle_control_unit_mem_wait_counter #(
      .MEM_LATENCY (MEM_LATENCY)
   ) u_wait (
      .i_clk    (clk),
      .i_rst_n  (reset),
      .i_clear  (w_wait_clear),
      .i_enable (w_wait_en),
      .o_last   (w_last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IF;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      pc_write    = 1'b0;
      pc_source   = PC_SRC_ALU;
      i_or_d      = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = ALU_SRC_A_PC;
      alu_src_b   = ALU_SRC_B_RS2;
      alu_op_mode = ALU_MODE_ADD;
      is_halted   = 1'b0;

      unique case (r_state)
         ST_IF: begin
            mem_read = 1'b1;
            if (w_last) begin
               ir_write = 1'b1;
               w_next   = ST_ID;
            end
         end

         ST_ID: begin
            // PC + imm lands in ALUOut as the branch/JAL target
            alu_src_a   = ALU_SRC_A_PC;
            alu_src_b   = ALU_SRC_B_IMM;
            alu_op_mode = ALU_MODE_ADD;
            case (opcode)
               OP_ARITHMETIC, OP_ARITHMETIC_IMM, OP_LOAD, OP_STORE,
               OP_BRANCH, OP_JAL, OP_JALR: w_next = ST_EX;
               OP_ECALL:                   w_next = ecall_halt ? ST_HALT : ST_PC4;
               default:                    w_next = ST_PC4;
            endcase
         end

         ST_EX: begin
            case (opcode)
               OP_ARITHMETIC: begin
                  alu_src_a   = ALU_SRC_A_RS1;
                  alu_src_b   = ALU_SRC_B_RS2;
                  alu_op_mode = ALU_MODE_FUNCT;
                  w_next      = ST_WB;
               end
               OP_ARITHMETIC_IMM: begin
                  alu_src_a   = ALU_SRC_A_RS1;
                  alu_src_b   = ALU_SRC_B_IMM;
                  alu_op_mode = ALU_MODE_FUNCT;
                  w_next      = ST_WB;
               end
               OP_LOAD, OP_STORE: begin
                  alu_src_a   = ALU_SRC_A_RS1;
                  alu_src_b   = ALU_SRC_B_IMM;
                  alu_op_mode = ALU_MODE_ADD;
                  w_next      = ST_MEM;
               end
               OP_BRANCH: begin
                  alu_src_a   = ALU_SRC_A_RS1;
                  alu_src_b   = ALU_SRC_B_RS2;
                  alu_op_mode = ALU_MODE_BRANCH;
                  if (bcond) begin
                     pc_write  = 1'b1;
                     pc_source = PC_SRC_ALUOUT;
                     w_next    = ST_IF;
                  end else begin
                     w_next    = ST_PC4;
                  end
               end
               OP_JAL: begin
                  // PC takes the target from ALUOut while the ALU forms the
                  // link address (old PC + 4) for the WB cycle.
                  pc_write    = 1'b1;
                  pc_source   = PC_SRC_ALUOUT;
                  alu_src_a   = ALU_SRC_A_PC;
                  alu_src_b   = ALU_SRC_B_FOUR;
                  alu_op_mode = ALU_MODE_ADD;
                  w_next      = ST_WB;
               end
               OP_JALR: begin
                  alu_src_a   = ALU_SRC_A_PC;
                  alu_src_b   = ALU_SRC_B_FOUR;
                  alu_op_mode = ALU_MODE_ADD;
                  w_next      = ST_WB;
               end
               default: w_next = ST_PC4;
            endcase
         end

         ST_MEM: begin
            i_or_d    = 1'b1;
            mem_read  = (opcode == OP_LOAD);
            mem_write = (opcode == OP_STORE);
            if (w_last) begin
               w_next = (opcode == OP_LOAD) ? ST_WB : ST_PC4;
            end
         end

         ST_WB: begin
            case (opcode)
               OP_ARITHMETIC, OP_ARITHMETIC_IMM, OP_LOAD: begin
                  reg_write   = 1'b1;
                  mem_to_reg  = (opcode == OP_LOAD);
                  alu_src_a   = ALU_SRC_A_PC;
                  alu_src_b   = ALU_SRC_B_FOUR;
                  alu_op_mode = ALU_MODE_ADD;
                  pc_write    = 1'b1;
                  pc_source   = PC_SRC_ALU;
               end
               OP_JAL: begin
                  // PC was already redirected in EX
                  reg_write   = 1'b1;
               end
               OP_JALR: begin
                  reg_write   = 1'b1;
                  alu_src_a   = ALU_SRC_A_RS1;
                  alu_src_b   = ALU_SRC_B_IMM;
                  alu_op_mode = ALU_MODE_ADD;
                  pc_write    = 1'b1;
                  pc_source   = PC_SRC_ALU;
               end
               default: ;
            endcase
            w_next = ST_IF;
         end

         ST_PC4: begin
            alu_src_a   = ALU_SRC_A_PC;
            alu_src_b   = ALU_SRC_B_FOUR;
            alu_op_mode = ALU_MODE_ADD;
            pc_write    = 1'b1;
            pc_source   = PC_SRC_ALU;
            w_next      = ST_IF;
         end

         ST_HALT: begin
            is_halted = 1'b1;
            w_next    = ST_HALT;
         end

         default: w_next = ST_IF;
      endcase

      // Reset silences every strobe immediately, independent of the clock.
      if (!reset) begin
         pc_write    = 1'b0;
         pc_source   = 1'b0;
         i_or_d      = 1'b0;
         mem_read    = 1'b0;
         mem_write   = 1'b0;
         ir_write    = 1'b0;
         mem_to_reg  = 1'b0;
         reg_write   = 1'b0;
         alu_src_a   = 1'b0;
         alu_src_b   = 2'b00;
         alu_op_mode = 2'b00;
         is_halted   = 1'b0;
      end
   end

`ifdef PERF_COUNTER_EN
   logic [31:0] r_cycle_count;
   logic [31:0] r_retired_count;
   logic        w_retire;

   assign w_retire = ((w_next == ST_IF)   && (r_state != ST_IF)) ||
                     ((w_next == ST_HALT) && (r_state != ST_HALT));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cycle_count   <= '0;
         r_retired_count <= '0;
      end else begin
         if (r_state != ST_HALT) begin
            r_cycle_count <= r_cycle_count + 32'd1;
         end
         if (w_retire) begin
            r_retired_count <= r_retired_count + 32'd1;
         end
      end
   end

   assign cycle_count   = r_cycle_count;
   assign retired_count = r_retired_count;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//   Two instances: MEM_LATENCY = 1 (u_dut1) and MEM_LATENCY = 3 (u_dut3).
//   Each directed scenario pushes its hand-derived per-cycle control vectors
//   into the queue of the instance under test; a monitor pops one entry per
//   cycle on the falling edge and compares it with the live outputs.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

   typedef struct packed {
      logic       pc_write;
      logic       pc_source;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op_mode;
      logic       is_halted;
   } ctl_t;

   typedef enum {
      S_Z, S_IF, S_IFL, S_ID,
      S_EX_R, S_EX_I, S_EX_LS, S_EX_BT, S_EX_BN, S_EX_JAL, S_EX_JALR,
      S_MEM_LD, S_MEM_ST,
      S_WB_ALU, S_WB_LD, S_WB_JAL, S_WB_JALR,
      S_PC4, S_HALT
   } step_t;

   localparam logic [6:0] OPC_R     = 7'b0110011;
   localparam logic [6:0] OPC_I     = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_BR    = 7'b1100011;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_ECALL = 7'b1110011;

   logic       clk = 1'b0;
   logic       rst1_n, rst3_n;
   logic [6:0] opcode;
   logic       bcond, ecall_halt;

   logic       p1_pcw, p1_pcs, p1_iod, p1_mr, p1_mw, p1_irw, p1_m2r, p1_rw, p1_asa, p1_hlt;
   logic [1:0] p1_asb, p1_mode;
   logic       p3_pcw, p3_pcs, p3_iod, p3_mr, p3_mw, p3_irw, p3_m2r, p3_rw, p3_asa, p3_hlt;
   logic [1:0] p3_asb, p3_mode;
   ctl_t       act1, act3;

   ctl_t       q1[$];
   ctl_t       q3[$];
   step_t      plan[$];
   string      cur_name;
   int         step_idx;
   int         n_chk;
   int         n_fail;

   always #5 clk = ~clk;

   multicycle_control_unit #(.MEM_LATENCY(1)) u_dut1 (
      .clk(clk), .reset(rst1_n), .opcode(opcode), .bcond(bcond), .ecall_halt(ecall_halt),
      .pc_write(p1_pcw), .pc_source(p1_pcs), .i_or_d(p1_iod), .mem_read(p1_mr),
      .mem_write(p1_mw), .ir_write(p1_irw), .mem_to_reg(p1_m2r), .reg_write(p1_rw),
      .alu_src_a(p1_asa), .alu_src_b(p1_asb), .alu_op_mode(p1_mode), .is_halted(p1_hlt)
   );

   multicycle_control_unit #(.MEM_LATENCY(3)) u_dut3 (
      .clk(clk), .reset(rst3_n), .opcode(opcode), .bcond(bcond), .ecall_halt(ecall_halt),
      .pc_write(p3_pcw), .pc_source(p3_pcs), .i_or_d(p3_iod), .mem_read(p3_mr),
      .mem_write(p3_mw), .ir_write(p3_irw), .mem_to_reg(p3_m2r), .reg_write(p3_rw),
      .alu_src_a(p3_asa), .alu_src_b(p3_asb), .alu_op_mode(p3_mode), .is_halted(p3_hlt)
   );

   assign act1 = {p1_pcw, p1_pcs, p1_iod, p1_mr, p1_mw, p1_irw, p1_m2r, p1_rw,
                  p1_asa, p1_asb, p1_mode, p1_hlt};
   assign act3 = {p3_pcw, p3_pcs, p3_iod, p3_mr, p3_mw, p3_irw, p3_m2r, p3_rw,
                  p3_asa, p3_asb, p3_mode, p3_hlt};

   // Hand-derived control vector for each cycle kind
   function automatic ctl_t exp_of(input step_t s);
      ctl_t e;
      e = '0;
      case (s)
         S_IF:      e.mem_read = 1'b1;
         S_IFL:     begin e.mem_read = 1'b1; e.ir_write = 1'b1; end
         S_ID:      e.alu_src_b = 2'b10;
         S_EX_R:    begin e.alu_src_a = 1'b1; e.alu_op_mode = 2'b10; end
         S_EX_I:    begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op_mode = 2'b10; end
         S_EX_LS:   begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
         S_EX_BT:   begin e.alu_src_a = 1'b1; e.alu_op_mode = 2'b01;
                          e.pc_write = 1'b1; e.pc_source = 1'b1; end
         S_EX_BN:   begin e.alu_src_a = 1'b1; e.alu_op_mode = 2'b01; end
         S_EX_JAL:  begin e.pc_write = 1'b1; e.pc_source = 1'b1; e.alu_src_b = 2'b01; end
         S_EX_JALR: e.alu_src_b = 2'b01;
         S_MEM_LD:  begin e.i_or_d = 1'b1; e.mem_read = 1'b1; end
         S_MEM_ST:  begin e.i_or_d = 1'b1; e.mem_write = 1'b1; end
         S_WB_ALU:  begin e.reg_write = 1'b1; e.alu_src_b = 2'b01; e.pc_write = 1'b1; end
         S_WB_LD:   begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                          e.alu_src_b = 2'b01; e.pc_write = 1'b1; end
         S_WB_JAL:  e.reg_write = 1'b1;
         S_WB_JALR: begin e.reg_write = 1'b1; e.alu_src_a = 1'b1;
                          e.alu_src_b = 2'b10; e.pc_write = 1'b1; end
         S_PC4:     begin e.alu_src_b = 2'b01; e.pc_write = 1'b1; end
         S_HALT:    e.is_halted = 1'b1;
         default:   e = '0;
      endcase
      return e;
   endfunction

   function automatic void check(input ctl_t a, input ctl_t e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %b want %b", cur_name, step_idx, a, e);
      end
      step_idx++;
   endfunction

   // Monitor: one expected vector per cycle while a queue holds entries
   always @(negedge clk) begin
      if (q1.size() != 0) check(act1, q1.pop_front());
      if (q3.size() != 0) check(act3, q3.pop_front());
   end

   // Hold the selected instance in reset for one checked cycle, queue the plan,
   // then release so that the next falling edge sees the first IF cycle.
   task automatic start(input int d, input string nm, input logic [6:0] op,
                        input logic bc, input logic eh);
      @(posedge clk); #1;
      cur_name   = nm;
      step_idx   = 0;
      opcode     = op;
      bcond      = bc;
      ecall_halt = eh;
      if (d == 1) begin rst1_n = 1'b0; q1.push_back(ctl_t'(0)); end
      else        begin rst3_n = 1'b0; q3.push_back(ctl_t'(0)); end
      @(posedge clk); #1;
      foreach (plan[i]) begin
         if (d == 1) q1.push_back(exp_of(plan[i]));
         else        q3.push_back(exp_of(plan[i]));
      end
      if (d == 1) rst1_n = 1'b1;
      else        rst3_n = 1'b1;
   endtask

   task automatic drain(input int d);
      int budget;
      budget = 60;
      while (budget > 0 && ((d == 1) ? q1.size() : q3.size()) != 0) begin
         @(posedge clk);
         budget--;
      end
      if (((d == 1) ? q1.size() : q3.size()) != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s timeout: %0d vectors left, want 0", cur_name,
                  (d == 1) ? q1.size() : q3.size());
         q1.delete();
         q3.delete();
      end
   endtask

   task automatic run(input int d, input string nm, input logic [6:0] op,
                      input logic bc, input logic eh);
      start(d, nm, op, bc, eh);
      drain(d);
   endtask

   initial begin
      logic [6:0] noise [8];
      noise = '{7'b0110011, 7'b1100011, 7'b0000011, 7'b1110011,
                7'b1101111, 7'b0100011, 7'b0000000, 7'b1111111};
      n_chk = 0; n_fail = 0; step_idx = 0; cur_name = "init";
      rst1_n = 1'b0; rst3_n = 1'b0;
      opcode = '0; bcond = 1'b0; ecall_halt = 1'b0;

      // MEM_LATENCY = 1
      plan = '{S_IFL, S_ID, S_EX_R, S_WB_ALU, S_IFL};
      run(1, "r_type", OPC_R, 1'b0, 1'b0);
      plan = '{S_IFL, S_ID, S_EX_I, S_WB_ALU, S_IFL};
      run(1, "i_type", OPC_I, 1'b0, 1'b0);
      plan = '{S_IFL, S_ID, S_EX_BT, S_IFL};
      run(1, "br_taken", OPC_BR, 1'b1, 1'b0);
      plan = '{S_IFL, S_ID, S_EX_BN, S_PC4, S_IFL};
      run(1, "br_not_taken", OPC_BR, 1'b0, 1'b0);
      plan = '{S_IFL, S_ID, S_EX_JAL, S_WB_JAL, S_IFL};
      run(1, "jal", OPC_JAL, 1'b0, 1'b0);
      plan = '{S_IFL, S_ID, S_EX_JALR, S_WB_JALR, S_IFL};
      run(1, "jalr", OPC_JALR, 1'b0, 1'b0);
      plan = '{S_IFL, S_ID, S_EX_LS, S_MEM_LD, S_WB_LD, S_IFL};
      run(1, "load_lat1", OPC_LOAD, 1'b0, 1'b0);
      plan = '{S_IFL, S_ID, S_EX_LS, S_MEM_ST, S_PC4, S_IFL};
      run(1, "store_lat1", OPC_STORE, 1'b0, 1'b0);
      plan = '{S_IFL, S_ID, S_PC4, S_IFL};
      run(1, "ecall_no_halt", OPC_ECALL, 1'b0, 1'b0);
      plan = '{S_IFL, S_ID, S_PC4, S_IFL};
      run(1, "unknown_nop", 7'b0000000, 1'b0, 1'b0);

      // ECALL halt: 20 halted cycles while the inputs keep changing
      plan = '{S_IFL, S_ID};
      repeat (20) plan.push_back(S_HALT);
      start(1, "ecall_halt", OPC_ECALL, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      for (int i = 0; i < 20; i++) begin
         #2;
         opcode     = noise[i % 8];
         bcond      = (i % 2) == 1;
         ecall_halt = (i % 3) == 0;
         @(posedge clk);
      end
      drain(1);
      rst1_n = 1'b0;

      // MEM_LATENCY = 3
      plan = '{S_IF, S_IF, S_IFL, S_ID, S_EX_LS, S_MEM_LD, S_MEM_LD, S_MEM_LD,
               S_WB_LD, S_IF};
      run(3, "load_lat3", OPC_LOAD, 1'b0, 1'b0);

      // Reset pulled low during the 2nd MEM cycle of a store
      plan = '{S_IF, S_IF, S_IFL, S_ID, S_EX_LS, S_MEM_ST, S_Z,
               S_IF, S_IF, S_IFL, S_ID};
      start(3, "store_mid_reset", OPC_STORE, 1'b0, 1'b0);
      repeat (6) @(posedge clk);
      #2 rst3_n = 1'b0;
      @(posedge clk);
      #1 rst3_n = 1'b1;
      drain(3);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
